sound_stream_sched: RTL and testbench
=====================================

// Module: sound_stream_sched
// PURPOSE
//  Sample-rate scheduler in front of the 8-bit sound DAC register. Arbitrates between legacy
//  direct writes (beeper, covox) and a buffered covox stream. CPU fills a small FIFO; a
//  programmable divider pops one sample per period into 'sound'. Sits between the port
//  decoder and the PWM/SDM DAC.
// PARAMETERS
//  FIFO_DEPTH  16      FIFO entries; power of 2, >= 4
//  DIV_W       12      sample-period divider width
//  DIV_RESET   12'd1749  divider reset value (period = div+1 clocks)
// PORTS
//  clk         in   1            system clock
//  rst_n       in   1            async reset, active low
//  din         in   8            CPU write data
//  beeper_wr   in   1            beeper port write strobe (1 clk)
//  covox_wr    in   1            direct covox write strobe
//  fifo_wr     in   1            buffered covox write strobe (push din)
//  ctrl_wr     in   1            control write: din[0]=stream_en, din[1]=clear (self-clearing)
//  div_lo_wr   in   1            div[7:0] <= din
//  div_hi_wr   in   1            div[DIV_W-1:8] <= din[DIV_W-9:0]
//  sound       out  8            DAC sample (registered)
//  fifo_level  out  $clog2(D)+1  current FIFO occupancy, 0..FIFO_DEPTH
//  fifo_full   out  1            level == FIFO_DEPTH
//  underrun    out  1            sticky: tick in PLAY with empty FIFO
//  overflow    out  1            sticky: push while full
//  half_req    out  1            stream_en && level < FIFO_DEPTH/2 (refill request)
// BEHAVIOUR
//  - Reset: sound=0, level=0, ptrs=0, state=DIRECT, stream_en=0, div=DIV_RESET, stickies=0, cnt=0.
//  - Divider: cnt increments every clk; when cnt==div, tick=1 and cnt<=0. Runs in all states.
//    Divider write reloads cnt<=0 the same edge. div=0 -> tick every clk.
//  - FSM:
//    DIRECT: covox_wr -> sound<=din; else beeper_wr -> sound<=din[4]?8'hFF:8'h00 (covox wins).
//            stream_en=1 -> PRIME.
//    PRIME : sound held; direct writes ignored; level>=FIFO_DEPTH/2 -> PLAY.
//    PLAY  : on tick, level>0 -> pop, sound<=head (visible 1 clk after tick edge);
//            level==0 -> underrun<=1, sound held, -> PRIME. Direct writes ignored.
//    Any state: stream_en=0 -> DIRECT next clk; FIFO contents kept; sound holds last value.
//  - FIFO: push on fifo_wr when not full; push when full dropped, overflow<=1.
//    Push+pop same clk: level unchanged, both pointers advance. Pointers wrap mod FIFO_DEPTH.
//    Push into empty FIFO not poppable in the same clk (no fall-through).
//  - clear (ctrl_wr & din[1]): ptrs/level<=0, underrun/overflow<=0; beats a same-clk push
//    and pop; stream_en updated from din[0] same edge; PLAY/PRIME -> PRIME.
//  - fifo_wr accepted in all states (pre-fill while DIRECT allowed).
//  - Reset mid-stream: all state returns to reset values immediately (async assert);
//    deassertion is synchronized by the top-level reset generator.
// STRUCTURE
//  - sound_defs.vh: FSM state encodings (DIRECT/PRIME/PLAY), ctrl bit indices
//    (CTRL_STREAM_EN=0, CTRL_CLEAR=1), DIV_RESET default.
//  - Sub-module sound_fifo: sync FIFO (push, pop, clr, dout, level, full, empty), async
//    active-low reset on pointers/level only; storage array not reset.
//  - Top holds divider, FSM, sound register, stickies.
// TESTING
//  1 Reset, covox_wr din=8'h5A then beeper_wr din=8'h10 -> sound 8'h5A, then 8'hFF;
//    covox_wr+beeper_wr same clk din=8'h33 -> sound 8'h33.
//  2 div=3, push 8 samples 1..8, stream_en=1 -> PRIME->PLAY; sound steps 1..8 every 4 clks,
//    change 1 clk after tick; then underrun=1, state PRIME, sound stays 8.
//  3 Push 17 while DIRECT (depth 16) -> fifo_full=1, level=16, overflow=1; 17th value never played.
//  4 PLAY with level=5, push and tick same clk -> level stays 5, order preserved.
//  5 ctrl_wr din=8'h03 with fifo_wr same clk, level=6 -> level=0, stickies=0, state PRIME,
//    half_req=1.
//  6 Assert rst_n=0 mid-PLAY -> sound=0, level=0, div=DIV_RESET, state DIRECT, without clk edge.

Source files
------------

// File: rtl/sound_stream_sched_pkg.sv
// Shared constants and types for the sound stream scheduler.
package sound_stream_sched_pkg;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int DIV_W_DEF      = 12;
  localparam logic [DIV_W_DEF-1:0] DIV_RESET_DEF = 12'd1749;

  // Bit positions inside the control-register write data
  localparam int CTRL_STREAM_EN = 0;
  localparam int CTRL_CLEAR     = 1;

  typedef enum logic [1:0] {
    ST_DIRECT = 2'd0,  // legacy beeper/covox writes drive the DAC
    ST_PRIME  = 2'd1,  // streaming enabled, waiting for FIFO to half-fill
    ST_PLAY   = 2'd2   // streaming, one sample popped per divider tick
  } state_t;

  // Beeper drives full-scale on/off from data bit 4
  function automatic logic [7:0] beeper_level(input logic [7:0] d);
    return d[4] ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/sound_stream_sched_fifo.sv
// Small synchronous sample FIFO. Pointers and level are reset; storage is not.
module sound_fifo
  import sound_stream_sched_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // Clear wins over both a push and a pop in the same cycle
  assign push_ok = push && !full && !clr;
  assign pop_ok  = pop && !empty && !clr;
  assign dout    = mem[rd_ptr];

  // Sample storage write
  // NOTE: storage has no reset; occupancy is tracked by pointers/level, so stale data is never read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sound_stream_sched.sv
// Sample-rate scheduler feeding the 8-bit sound DAC register: legacy direct
// writes or a divider-paced buffered covox stream.
module sound_stream_sched
  import sound_stream_sched_pkg::*;
#(
  parameter int               FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int               DIV_W      = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_RESET  = DIV_RESET_DEF,
  parameter int               LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    din,
  input  logic          beeper_wr,
  input  logic          covox_wr,
  input  logic          fifo_wr,
  input  logic          ctrl_wr,
  input  logic          div_lo_wr,
  input  logic          div_hi_wr,
  output logic [7:0]    sound,
  output logic [LW-1:0] fifo_level,
  output logic          fifo_full,
  output logic          underrun,
  output logic          overflow,
  output logic          half_req
);

  localparam logic [LW-1:0] HALF = LW'(FIFO_DEPTH / 2);

  state_t           state, next_state;
  logic [DIV_W-1:0] div, cnt;
  logic             tick, clear, stream_en;
  logic             pop, starve, fifo_empty;
  logic [7:0]       fifo_dout, sound_next;

  assign tick     = (cnt == div);
  assign clear    = ctrl_wr && din[CTRL_CLEAR];
  assign half_req = stream_en && (fifo_level < HALF);

  sound_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_wr),
    .pop   (pop),
    .clr   (clear),
    .din   (din),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sample-period divider and its programmable period register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= DIV_RESET;
      cnt <= '0;
    end else begin
      if (div_lo_wr) div[7:0]       <= din;
      if (div_hi_wr) div[DIV_W-1:8] <= din[DIV_W-9:0];
      if (div_lo_wr || div_hi_wr) cnt <= '0;
      else if (tick)              cnt <= '0;
      else                        cnt <= cnt + DIV_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_DIRECT;
    else        state <= next_state;
  end

  // FSM next-state: disabling always returns to DIRECT, clear re-primes
  always_comb begin
    next_state = state;
    if (!stream_en) begin
      next_state = ST_DIRECT;
    end else if (clear && state != ST_DIRECT) begin
      next_state = ST_PRIME;
    end else begin
      case (state)
        ST_DIRECT: next_state = ST_PRIME;
        ST_PRIME:  if (fifo_level >= HALF) next_state = ST_PLAY;
        ST_PLAY:   if (starve) next_state = ST_PRIME;
        default:   next_state = ST_DIRECT;
      endcase
    end
  end

  // FSM outputs: next DAC value, FIFO pop and starvation detect
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    sound_next = sound;
    pop        = 1'b0;
    starve     = 1'b0;
    case (state)
      ST_DIRECT: begin
        if (covox_wr)       sound_next = din;
        else if (beeper_wr) sound_next = beeper_level(din);
      end
      ST_PLAY: begin
        if (stream_en && tick && !clear) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            sound_next = fifo_dout;
          end else begin
            starve = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // DAC sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sound <= 8'h00;
    else        sound <= sound_next;
  end

  // Stream enable and sticky error flags; clear beats same-cycle events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stream_en <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ctrl_wr) stream_en <= din[CTRL_STREAM_EN];
      if (clear) begin
        underrun <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (starve)               underrun <= 1'b1;
        if (fifo_wr && fifo_full) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sound_stream_sched.sv
// Self-checking bench: direct-write vector table, hand-written streaming
// sequences, and randomized traffic against a queue-based reference model.
module tb_sound_stream_sched;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       beeper_wr = 0, covox_wr = 0, fifo_wr = 0, ctrl_wr = 0;
  logic       div_lo_wr = 0, div_hi_wr = 0;
  logic [7:0] sound;
  logic [4:0] fifo_level;
  logic       fifo_full, underrun, overflow, half_req;

  sound_stream_sched dut (
    .clk(clk), .rst_n(rst_n), .din(din),
    .beeper_wr(beeper_wr), .covox_wr(covox_wr), .fifo_wr(fifo_wr),
    .ctrl_wr(ctrl_wr), .div_lo_wr(div_lo_wr), .div_hi_wr(div_hi_wr),
    .sound(sound), .fifo_level(fifo_level), .fifo_full(fifo_full),
    .underrun(underrun), .overflow(overflow), .half_req(half_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_DIRECT, M_PRIME, M_PLAY} mode_t;
  byte unsigned m_q[$];
  int           m_cnt, m_div;
  mode_t        m_mode;
  logic [7:0]   m_sound;
  bit           m_en, m_under, m_over;

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0; m_div = 1749; m_mode = M_DIRECT;
    m_sound = 8'h00; m_en = 0; m_under = 0; m_over = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs
  task automatic model_step();
    bit    tick   = (m_cnt == m_div);
    bit    clr    = ctrl_wr && din[1];
    int    n      = m_q.size();
    bit    play   = (m_mode == M_PLAY) && m_en && tick && !clr;
    bit    starve = play && (n == 0);
    mode_t nm;
    if (!m_en)                           nm = M_DIRECT;
    else if (clr && m_mode != M_DIRECT)  nm = M_PRIME;
    else if (m_mode == M_DIRECT)         nm = M_PRIME;
    else if (m_mode == M_PRIME)          nm = (n >= DEPTH / 2) ? M_PLAY : M_PRIME;
    else                                 nm = starve ? M_PRIME : M_PLAY;
    if (m_mode == M_DIRECT) begin
      if (covox_wr)       m_sound = din;
      else if (beeper_wr) m_sound = din[4] ? 8'hFF : 8'h00;
    end
    if (play && n > 0) m_sound = m_q.pop_front();
    if (fifo_wr && !clr) begin
      if (n == DEPTH) m_over = 1;
      else            m_q.push_back(din);
    end
    if (starve) m_under = 1;
    if (clr) begin m_q.delete(); m_under = 0; m_over = 0; end
    if (ctrl_wr) m_en = din[0];
    if (div_lo_wr || div_hi_wr) m_cnt = 0;
    else                        m_cnt = tick ? 0 : m_cnt + 1;
    if (div_lo_wr) m_div = (m_div & 32'hF00) | int'(din);
    if (div_hi_wr) m_div = (m_div & 32'h0FF) | (int'(din[3:0]) << 8);
    m_mode = nm;
  endtask

  task automatic compare_all();
    check("sound",      32'(sound),      32'(m_sound));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("fifo_full",  32'(fifo_full),  32'(m_q.size() == DEPTH));
    check("underrun",   32'(underrun),   32'(m_under));
    check("overflow",   32'(overflow),   32'(m_over));
    check("half_req",   32'(half_req),   32'(m_en && m_q.size() < DEPTH / 2));
  endtask

  // One clock: model and DUT both consume the driven inputs, then strobes drop
  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    compare_all();
    beeper_wr = 0; covox_wr = 0; fifo_wr = 0; ctrl_wr = 0;
    div_lo_wr = 0; div_hi_wr = 0;
  endtask

  task automatic ctrl(input logic [7:0] v);
    ctrl_wr = 1; din = v; cyc();
  endtask

  task automatic push(input logic [7:0] v);
    fifo_wr = 1; din = v; cyc();
  endtask

  task automatic set_div(input int v);
    div_lo_wr = 1; din = 8'(v); cyc();
    div_hi_wr = 1; din = 8'(v >> 8); cyc();
  endtask

  typedef struct {
    bit         covox;
    bit         beeper;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic [7:0] prev;
    int         chg_vals[$], chg_cyc[$];
    bit         seen_last;
    int         guard;

    vecs[0] = '{1, 0, 8'h5A, 8'h5A};
    vecs[1] = '{0, 1, 8'h10, 8'hFF};
    vecs[2] = '{1, 1, 8'h33, 8'h33};
    vecs[3] = '{0, 1, 8'hEF, 8'h00};
    vecs[4] = '{0, 1, 8'h1F, 8'hFF};
    vecs[5] = '{0, 0, 8'hC4, 8'hFF};

    // Reset state
    model_reset();
    #12;
    check("rst_sound", 32'(sound), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_flags", {28'h0, fifo_full, underrun, overflow, half_req}, 0);
    #10 rst_n = 1'b1;

    // 1: direct writes, covox wins over beeper
    foreach (vecs[i]) begin
      covox_wr = vecs[i].covox; beeper_wr = vecs[i].beeper; din = vecs[i].d;
      cyc();
      check($sformatf("direct_vec%0d", i), 32'(sound), 32'(vecs[i].exp));
    end

    // 2: div=3, eight samples, stream steps every 4 clocks, then underrun
    set_div(3);
    for (int i = 1; i <= 8; i++) push(8'(i));
    ctrl(8'h01);
    prev = sound;
    for (int c = 0; c < 80; c++) begin
      cyc();
      if (sound != prev) begin chg_vals.push_back(int'(sound)); chg_cyc.push_back(c); end
      prev = sound;
    end
    check("t2_changes", 32'(chg_vals.size()), 8);
    for (int i = 0; i < chg_vals.size() && i < 8; i++) begin
      check($sformatf("t2_val%0d", i), 32'(chg_vals[i]), 32'(i + 1));
      if (i > 0) check($sformatf("t2_gap%0d", i), 32'(chg_cyc[i] - chg_cyc[i-1]), 4);
    end
    check("t2_underrun", 32'(underrun), 1);
    check("t2_sound_hold", 32'(sound), 8);
    covox_wr = 1; din = 8'h77; cyc();
    check("t2_prime_ignores_covox", 32'(sound), 8);

    // 3: overfill while DIRECT; 17th value dropped and never played
    ctrl(8'h02);
    for (int i = 0; i < 17; i++) push(8'(100 + i));
    check("t3_full", 32'(fifo_full), 1);
    check("t3_level", 32'(fifo_level), 16);
    check("t3_overflow", 32'(overflow), 1);
    ctrl(8'h01);
    seen_last = 0;
    for (int c = 0; c < 100; c++) begin
      cyc();
      if (sound == 8'd116) seen_last = 1;
    end
    check("t3_last_played", 32'(sound), 115);
    check("t3_dropped_never_played", 32'(seen_last), 0);

    // 4: push coinciding with a pop at level 5
    ctrl(8'h03);
    for (int i = 0; i < 8; i++) push(8'(200 + i));
    guard = 0;
    while (!(m_mode == M_PLAY && m_q.size() == 5 && m_cnt == m_div) && guard < 100) begin
      cyc(); guard++;
    end
    check("t4_reached_level5", 32'(guard < 100), 1);
    fifo_wr = 1; din = 8'hAB; cyc();
    check("t4_level_kept", 32'(fifo_level), 5);
    for (int c = 0; c < 40; c++) cyc();
    check("t4_order_last", 32'(sound), 32'h0AB);

    // 5: clear with simultaneous push at level 6
    ctrl(8'h02);
    for (int i = 0; i < 17; i++) push(8'(i + 50));
    ctrl(8'h01);
    guard = 0;
    while (m_q.size() != 6 && guard < 200) begin cyc(); guard++; end
    check("t5_reached_level6", 32'(guard < 200), 1);
    ctrl_wr = 1; fifo_wr = 1; din = 8'h03; cyc();
    check("t5_level", 32'(fifo_level), 0);
    check("t5_overflow", 32'(overflow), 0);
    check("t5_underrun", 32'(underrun), 0);
    check("t5_half_req", 32'(half_req), 1);
    covox_wr = 1; din = 8'h77; cyc();
    check("t5_prime_ignores_covox", 32'(sound == 8'h77), 0);

    // 6: asynchronous reset mid-PLAY, then default divider in effect
    ctrl(8'h02);
    for (int i = 0; i < 8; i++) push(8'(i + 30));
    ctrl(8'h01);
    for (int c = 0; c < 20; c++) cyc();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_sound", 32'(sound), 0);
    check("t6_level", 32'(fifo_level), 0);
    check("t6_flags", {28'h0, fifo_full, underrun, overflow, half_req}, 0);
    #2 rst_n = 1'b1;
    covox_wr = 1; din = 8'h42; cyc();
    check("t6_direct_after_reset", 32'(sound), 32'h42);
    for (int i = 0; i < 8; i++) push(8'(i + 1));
    ctrl(8'h01);
    for (int c = 0; c < 1000; c++) cyc();
    check("t6_slow_default_div", 32'(sound), 32'h42);
    for (int c = 0; c < 800; c++) cyc();

    // Randomized traffic against the model
    ctrl(8'h02);
    for (int c = 0; c < 4000; c++) begin
      din       = 8'($urandom);
      fifo_wr   = ($urandom_range(0, 3) == 0);
      covox_wr  = ($urandom_range(0, 7) == 0);
      beeper_wr = ($urandom_range(0, 7) == 0);
      ctrl_wr   = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 199) == 0) begin
        div_lo_wr = 1;
        din = 8'($urandom_range(0, 7));
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
